// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the framed UART command parser:
// letter/command map, terminators, echo bytes, error codes and FSM states.
package uart_cmd_pkg;

   localparam logic [7:0] LETTER_U = 8'h55;
   localparam logic [7:0] LETTER_D = 8'h44;
   localparam logic [7:0] LETTER_R = 8'h52;
   localparam logic [7:0] LETTER_L = 8'h4C;
   localparam logic [7:0] LETTER_C = 8'h43;
   localparam logic [7:0] LETTER_O = 8'h4F;
   localparam logic [7:0] LETTER_Z = 8'h5A;
   localparam logic [7:0] LETTER_M = 8'h4D;

   localparam logic [2:0] CMD_U = 3'd0;
   localparam logic [2:0] CMD_D = 3'd1;
   localparam logic [2:0] CMD_R = 3'd2;
   localparam logic [2:0] CMD_L = 3'd3;
   localparam logic [2:0] CMD_C = 3'd4;
   localparam logic [2:0] CMD_O = 3'd5;
   localparam logic [2:0] CMD_Z = 3'd6;
   localparam logic [2:0] CMD_M = 3'd7;

   localparam logic [7:0] TERM_CR   = 8'h0D;
   localparam logic [7:0] TERM_LF   = 8'h0A;
   localparam logic [7:0] ECHO_ACK  = 8'h06;
   localparam logic [7:0] ECHO_NAK  = 8'h15;
   // Clearing bit 5 folds lower-case ASCII letters onto upper case.
   localparam logic [7:0] CASE_MASK = 8'hDF;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BYTE    = 2'd1,
      ERR_RANGE   = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARG     = 2'd1,
`ifdef UART_CMD_ECHO_EN
      ST_DISCARD = 2'd2,
      ST_ECHO    = 2'd3
`else
      ST_DISCARD = 2'd2
`endif
   } parse_state_e;

   // Returns {hit, command index} for a received byte.
   function automatic logic [3:0] letter_lookup(input logic [7:0] b);
      logic [3:0] r;
      r = 4'b0000;
      case (b & CASE_MASK)
         LETTER_U: r = {1'b1, CMD_U};
         LETTER_D: r = {1'b1, CMD_D};
         LETTER_R: r = {1'b1, CMD_R};
         LETTER_L: r = {1'b1, CMD_L};
         LETTER_C: r = {1'b1, CMD_C};
         LETTER_O: r = {1'b1, CMD_O};
         LETTER_Z: r = {1'b1, CMD_Z};
         LETTER_M: r = {1'b1, CMD_M};
         default:  r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_cmd_pulse_stretch.sv
// Holds the one-hot command pulse and its argument for PULSE_LEN cycles.
// A load while a pulse is active replaces bit and argument and restarts the count.
module uart_cmd_pulse_stretch #(
   parameter int PULSE_LEN = 1,
   parameter int ARG_W     = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [2:0]       load_idx,
   input  logic [ARG_W-1:0] load_arg,
   output logic [7:0]       cmd_pulse,
   output logic [ARG_W-1:0] cmd_arg
);

   localparam logic [7:0] LEN_V = 8'(PULSE_LEN);

   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_pulse <= 8'h00;
         cmd_arg   <= '0;
         cnt_q     <= 8'd0;
      end else if (load) begin
         cmd_pulse <= 8'h01 << load_idx;
         cmd_arg   <= load_arg;
         cnt_q     <= LEN_V;
      end else if (cnt_q != 8'd0) begin
         cnt_q <= cnt_q - 8'd1;
         if (cnt_q == 8'd1) begin
            cmd_pulse <= 8'h00;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command parser: LETTER [DIGITS] TERM -> stretched one-hot pulse,
// sticky mode register, error reporting. UART_CMD_ECHO_EN adds ACK/NAK echo.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int PULSE_LEN   = 1,
   parameter int ARG_W       = 8,
   parameter int MAX_DIGITS  = 3,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int NUM_MODES   = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_done,
   output logic [7:0]                   cmd_pulse,
   output logic [ARG_W-1:0]             cmd_arg,
   output logic [$clog2(NUM_MODES)-1:0] mode_q,
   output logic                         mode_change,
   output logic                         err,
   output logic [1:0]                   err_code,
   output logic [7:0]                   tx_data,
   output logic                         tx_start,
   input  logic                         tx_busy,
   output parse_state_e                 state_dbg
);

   localparam int MODE_W = $clog2(NUM_MODES);
   localparam int ACC_W  = ARG_W + 4;
   localparam int DIG_W  = $clog2(MAX_DIGITS + 1);
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ACC_W-1:0]  NUM_MODES_V = ACC_W'(NUM_MODES);
   localparam logic [DIG_W-1:0]  MAX_DIG_V   = DIG_W'(MAX_DIGITS);
   localparam logic [TCNT_W-1:0] TMO_LAST    = TCNT_W'(TIMEOUT_CYC - 1);

`ifdef UART_CMD_ECHO_EN
   localparam parse_state_e ST_AFTER = ST_ECHO;
   logic tx_go;
`else
   localparam parse_state_e ST_AFTER = ST_IDLE;
`endif

   // Handshakes: rx_done is a one-cycle strobe qualifying rx_data with no
   // backpressure; tx_start is a one-cycle request issued only when tx_busy=0.

   parse_state_e     state_q, state_d;
   logic [ARG_W-1:0] acc_q, acc_d;
   logic [DIG_W-1:0] ndig_q, ndig_d;
   logic [2:0]       idx_q, idx_d;
   logic [TCNT_W-1:0] tcnt_q;
   logic             exec_load, mode_wr, err_fire, nak_d;
   err_code_e        err_code_d;

   logic             is_term, is_digit, in_frame, tmo;
   logic [3:0]       lookup;
   logic [ACC_W-1:0] acc_wide, acc_next;

   assign is_term  = (rx_data == TERM_CR) || (rx_data == TERM_LF);
   assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign lookup   = letter_lookup(rx_data);
   assign acc_wide = {4'd0, acc_q};
   // acc*10 + d as shifts; ARG_W+4 bits cannot wrap for any ARG_W-bit acc.
   assign acc_next = (acc_wide << 3) + (acc_wide << 1) + {{ARG_W{1'b0}}, rx_data[3:0]};
   assign in_frame = (state_q == ST_ARG) || (state_q == ST_DISCARD);
   assign tmo      = in_frame && !rx_done && (tcnt_q == TMO_LAST);
   assign state_dbg = state_q;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      ndig_d     = ndig_q;
      idx_d      = idx_q;
      exec_load  = 1'b0;
      mode_wr    = 1'b0;
      err_fire   = 1'b0;
      err_code_d = ERR_NONE;
      nak_d      = 1'b0;
`ifdef UART_CMD_ECHO_EN
      tx_go      = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_done && !is_term) begin
               if (lookup[3]) begin
                  idx_d   = lookup[2:0];
                  acc_d   = '0;
                  ndig_d  = '0;
                  state_d = ST_ARG;
               end else begin
                  err_fire   = 1'b1;
                  err_code_d = ERR_BYTE;
                  nak_d      = 1'b1;
                  state_d    = ST_AFTER;
               end
            end
         end
         ST_ARG: begin
            if (rx_done) begin
               if (is_term) begin
                  state_d = ST_AFTER;
                  if (idx_q == CMD_M) begin
                     if (acc_wide < NUM_MODES_V) begin
                        mode_wr = 1'b1;
                     end else begin
                        err_fire   = 1'b1;
                        err_code_d = ERR_RANGE;
                        nak_d      = 1'b1;
                     end
                  end else begin
                     exec_load = 1'b1;
                  end
               end else if (is_digit) begin
                  if ((ndig_q == MAX_DIG_V) || (acc_next[ACC_W-1:ARG_W] != '0)) begin
                     err_fire   = 1'b1;
                     err_code_d = ERR_RANGE;
                     state_d    = ST_DISCARD;
                  end else begin
                     acc_d  = acc_next[ARG_W-1:0];
                     ndig_d = ndig_q + DIG_W'(1);
                  end
               end else begin
                  err_fire   = 1'b1;
                  err_code_d = ERR_BYTE;
                  state_d    = ST_DISCARD;
               end
            end else if (tmo) begin
               err_fire   = 1'b1;
               err_code_d = ERR_TIMEOUT;
               nak_d      = 1'b1;
               state_d    = ST_AFTER;
            end
         end
         ST_DISCARD: begin
            // The error was already reported when discarding began.
            if (rx_done) begin
               if (is_term) begin
                  nak_d   = 1'b1;
                  state_d = ST_AFTER;
               end
            end else if (tmo) begin
               err_fire   = 1'b1;
               err_code_d = ERR_TIMEOUT;
               nak_d      = 1'b1;
               state_d    = ST_AFTER;
            end
         end
`ifdef UART_CMD_ECHO_EN
         ST_ECHO: begin
            if (rx_done) begin
               err_fire   = 1'b1;
               err_code_d = ERR_BYTE;
            end
            if (!tx_busy) begin
               tx_go   = 1'b1;
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         ndig_q      <= '0;
         idx_q       <= 3'd0;
         tcnt_q      <= '0;
         mode_q      <= '0;
         mode_change <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ndig_q      <= ndig_d;
         idx_q       <= idx_d;
         if (!in_frame || rx_done || tmo) begin
            tcnt_q <= '0;
         end else begin
            tcnt_q <= tcnt_q + TCNT_W'(1);
         end
         mode_change <= mode_wr;
         if (mode_wr) begin
            mode_q <= acc_q[MODE_W-1:0];
         end
         err         <= err_fire;
         err_code    <= err_code_d;
      end
   end

   uart_cmd_pulse_stretch #(
      .PULSE_LEN (PULSE_LEN),
      .ARG_W     (ARG_W)
   ) u_stretch (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (exec_load),
      .load_idx  (idx_q),
      .load_arg  (acc_q),
      .cmd_pulse (cmd_pulse),
      .cmd_arg   (cmd_arg)
   );

`ifdef UART_CMD_ECHO_EN
   logic nak_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nak_q    <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         if (state_q != ST_ECHO) begin
            nak_q <= nak_d;
         end
         tx_start <= tx_go;
         tx_data  <= tx_go ? (nak_q ? ECHO_NAK : ECHO_ACK) : 8'h00;
      end
   end
`else
   logic unused_echo;
   assign unused_echo = nak_d ^ tx_busy;
   assign tx_start    = 1'b0;
   assign tx_data     = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame-level reference model compared
// every cycle, plus literal expectations at the points the timing rules define.
module tb_uart_cmd_parser;

   localparam int PULSE_LEN   = 4;
   localparam int ARG_W       = 8;
   localparam int MAX_DIGITS  = 3;
   localparam int TIMEOUT_CYC = 40;
   localparam int NUM_MODES   = 3;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_done = 1'b0;
   logic             tx_busy = 1'b0;
   logic [7:0]       cmd_pulse;
   logic [ARG_W-1:0] cmd_arg;
   logic [1:0]       mode_q;
   logic             mode_change;
   logic             err;
   logic [1:0]       err_code;
   logic [7:0]       tx_data;
   logic             tx_start;
   logic [1:0]       state_dbg;

   int total = 0;
   int bad   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   uart_cmd_parser #(
      .PULSE_LEN   (PULSE_LEN),
      .ARG_W       (ARG_W),
      .MAX_DIGITS  (MAX_DIGITS),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .NUM_MODES   (NUM_MODES)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .cmd_pulse   (cmd_pulse),
      .cmd_arg     (cmd_arg),
      .mode_q      (mode_q),
      .mode_change (mode_change),
      .err         (err),
      .err_code    (err_code),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .state_dbg   (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit         m_open, m_bad;
   int         m_idx, m_val, m_nd, m_idle, m_left;
   logic [7:0] m_pulse;
   logic [7:0] m_arg;
   logic [1:0] m_mode;
   logic       m_mc, m_err;
   logic [1:0] exp_q[$];

   function automatic int letter_index(input logic [7:0] b);
      string map = "UDRLCOZM";
      logic [7:0] u;
      u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'd32 : b;
      for (int i = 0; i < 8; i++) begin
         if (map[i] == u) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_open = 0; m_bad = 0; m_idx = 0; m_val = 0; m_nd = 0; m_idle = 0; m_left = 0;
      m_pulse = 8'h00; m_arg = 8'h00; m_mode = 2'd0; m_mc = 1'b0; m_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic flag_err(input logic [1:0] code);
      m_err = 1'b1;
      exp_q.push_back(code);
   endtask

   task automatic model_execute();
      if (m_idx == 7) begin
         if (m_val < NUM_MODES) begin
            m_mode = 2'(m_val);
            m_mc   = 1'b1;
         end else begin
            flag_err(2'd2);
         end
      end else begin
         m_pulse = 8'h01 << m_idx;
         m_arg   = 8'(m_val);
         m_left  = PULSE_LEN;
      end
   endtask

   // Predicts outputs after the next rising edge from the inputs it will sample.
   task automatic model_step(input logic done, input logic [7:0] b);
      bit term;
      int li;
      m_err = 1'b0;
      m_mc  = 1'b0;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_pulse = 8'h00;
      end
      if (done) begin
         m_idle = 0;
         term = (b == CR) || (b == LF);
         if (!m_open) begin
            if (!term) begin
               li = letter_index(b);
               if (li >= 0) begin
                  m_open = 1; m_bad = 0; m_idx = li; m_val = 0; m_nd = 0;
               end else begin
                  flag_err(2'd1);
               end
            end
         end else if (m_bad) begin
            if (term) m_open = 0;
         end else if (term) begin
            m_open = 0;
            model_execute();
         end else if (b >= 8'h30 && b <= 8'h39) begin
            if (m_nd == MAX_DIGITS) begin
               flag_err(2'd2); m_bad = 1;
            end else begin
               m_val = m_val * 10 + int'(b - 8'h30);
               m_nd++;
               if (m_val > (1 << ARG_W) - 1) begin
                  flag_err(2'd2); m_bad = 1;
               end
            end
         end else begin
            flag_err(2'd1); m_bad = 1;
         end
      end else if (m_open) begin
         m_idle++;
         if (m_idle == TIMEOUT_CYC) begin
            flag_err(2'd3);
            m_open = 0;
         end
      end
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (!reset_n) model_reset();
      chk("cmd_pulse", 32'(cmd_pulse), 32'(m_pulse));
      if (m_pulse != 8'h00) chk("cmd_arg", 32'(cmd_arg), 32'(m_arg));
      chk("mode_q", 32'(mode_q), 32'(m_mode));
      chk("mode_change", 32'(mode_change), 32'(m_mc));
      chk("err", 32'(err), 32'(m_err));
      if (m_err && exp_q.size() > 0) chk("err_code", 32'(err_code), 32'(exp_q.pop_front()));
`ifndef UART_CMD_ECHO_EN
      chk("tx_start", 32'(tx_start), 32'd0);
      chk("tx_data", 32'(tx_data), 32'd0);
`endif
      if (reset_n) model_step(rx_done, rx_data);
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_data = 8'($urandom_range(0, 255));
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      model_reset();
      idle(3);
      chk("lit_rst_pulse", 32'(cmd_pulse), 32'h0);
      chk("lit_rst_mode", 32'(mode_q), 32'h0);
      chk("lit_rst_err", 32'(err), 32'h0);
      reset_n = 1'b1;
      idle(2);

      // "u5\r": pulse bit 0 for PULSE_LEN cycles, argument 5
      send_str("u5"); send_byte(CR);
      chk("lit_u5_pulse", 32'(cmd_pulse), 32'h01);
      chk("lit_u5_arg", 32'(cmd_arg), 32'd5);
      for (int i = 0; i < PULSE_LEN - 1; i++) begin
         idle(1);
         chk("lit_u5_hold", 32'(cmd_pulse), 32'h01);
      end
      idle(1);
      chk("lit_u5_end", 32'(cmd_pulse), 32'h00);

      // mode write, then out-of-range mode
      send_str("M2"); send_byte(LF);
      chk("lit_m2_mode", 32'(mode_q), 32'd2);
      chk("lit_m2_change", 32'(mode_change), 32'd1);
      idle(1);
      chk("lit_m2_once", 32'(mode_change), 32'd0);
      send_str("M7"); send_byte(LF);
      chk("lit_m7_err", 32'(err), 32'd1);
      chk("lit_m7_code", 32'(err_code), 32'd2);
      chk("lit_m7_mode", 32'(mode_q), 32'd2);

      // overflow on third digit, remainder discarded
      send_str("D99"); send_byte("9");
      chk("lit_d999_err", 32'(err), 32'd1);
      chk("lit_d999_code", 32'(err_code), 32'd2);
      send_byte(CR);
      idle(6);

      // timeout after exactly TIMEOUT_CYC idle cycles
      send_str("R1");
      idle(TIMEOUT_CYC - 1);
      chk("lit_tmo_early", 32'(err), 32'd0);
      idle(1);
      chk("lit_tmo_err", 32'(err), 32'd1);
      chk("lit_tmo_code", 32'(err_code), 32'd3);
      send_str("L"); send_byte(CR);
      chk("lit_l_pulse", 32'(cmd_pulse), 32'h08);
      chk("lit_l_arg", 32'(cmd_arg), 32'd0);
      idle(5);

      // unknown letter in IDLE
      send_byte("X");
      chk("lit_x_err", 32'(err), 32'd1);
      chk("lit_x_code", 32'(err_code), 32'd1);

      // argument range edges and digit-count limit
      send_str("U255"); send_byte(CR);
      chk("lit_u255_arg", 32'(cmd_arg), 32'd255);
      idle(5);
      send_str("U256"); send_byte(CR);
      send_str("U0012"); send_byte(CR);
      idle(3);

      // byte arriving on the expiry cycle wins over the timeout
      send_str("C12");
      idle(TIMEOUT_CYC - 2);
      send_byte(CR);
      chk("lit_c12_pulse", 32'(cmd_pulse), 32'h10);
      chk("lit_c12_arg", 32'(cmd_arg), 32'd12);
      chk("lit_c12_noerr", 32'(err), 32'd0);
      idle(5);

      // new execute on the last stretch cycle replaces and reloads
      send_str("U1"); send_byte(CR);
      send_str("D"); send_byte(CR);
      chk("lit_repl_pulse", 32'(cmd_pulse), 32'h02);
      idle(PULSE_LEN - 1);
      chk("lit_repl_hold", 32'(cmd_pulse), 32'h02);
      idle(1);
      chk("lit_repl_end", 32'(cmd_pulse), 32'h00);

      // lowercase letter, stray terminator, non-digit argument
      send_str("z"); send_byte(CR);
      send_byte(LF);
      send_str("Ra"); send_byte(CR);
      idle(5);

      // reset mid-pulse and mid-frame
      send_str("O12"); send_byte(CR);
      send_byte("C");
      chk("lit_pre_rst_pulse", 32'(cmd_pulse), 32'h20);
      reset_n = 1'b0;
      #1;
      chk("lit_async_pulse", 32'(cmd_pulse), 32'h00);
      chk("lit_async_arg", 32'(cmd_arg), 32'h00);
      chk("lit_async_mode", 32'(mode_q), 32'h0);
      idle(2);
      reset_n = 1'b1;
      send_byte(CR);
      chk("lit_after_rst_err", 32'(err), 32'd0);
      chk("lit_after_rst_pulse", 32'(cmd_pulse), 32'h00);
      idle(5);

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Framed UART command parser: the parametrised successor to the single-byte UART command decoder. It sits between the UART receiver and the appliance control logic (mode FSMs, button-equivalent inputs). It accepts a command letter with an optional decimal argument and a line terminator, then emits a stretched one-hot command pulse with the parsed argument. It also holds a sticky mode register and reports parse errors.

## Interface
Parameters:
- PULSE_LEN, 1: cycles each cmd_pulse bit stays high (1..255).
- ARG_W, 8: argument width, bits.
- MAX_DIGITS, 3: maximum decimal digits per frame.
- TIMEOUT_CYC, 1000000: idle cycles allowed between bytes inside a frame.
- NUM_MODES, 3: number of legal mode values.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid when rx_done=1.
- rx_done  in  1  single-cycle byte strobe.
- cmd_pulse  out  8  one-hot command pulse; bit index from the package map.
- cmd_arg  out  ARG_W  parsed argument; stable while any cmd_pulse bit is high.
- mode_q  out  $clog2(NUM_MODES)  sticky mode register.
- mode_change  out  1  1-cycle pulse when mode_q is written.
- err  out  1  1-cycle error pulse.
- err_code  out  2  error cause, valid with err: 1 = unknown or dropped byte, 2 = range/overflow, 3 = timeout.
- tx_data  out  8  echo byte (UART_CMD_ECHO_EN only).
- tx_start  out  1  1-cycle transmit request (UART_CMD_ECHO_EN only).
- tx_busy  in  1  transmitter busy (UART_CMD_ECHO_EN only).

## Operation
- Frame format: LETTER, then DIGIT×(0..MAX_DIGITS), then TERM.
  - TERM is 0x0D or 0x0A.
  - Letters are case-insensitive: bit 5 is cleared before lookup.
- Letter map: U=0, D=1, R=2, L=3, C=4, O=5, Z=6, M=7.
- FSM states:
  - IDLE: a mapped letter latches the index, clears the accumulator and goes to ARG. TERM is ignored. Any other byte raises err, code 1.
  - ARG, on each byte:
    - Digit: acc = acc*10 + d, computed at ARG_W+4 bits. Overflow above 2^ARG_W−1, or more than MAX_DIGITS digits, raises err code 2 and goes to DISCARD.
    - TERM: executes the frame and returns to IDLE (or ECHO).
    - Any other byte: err code 1, go to DISCARD.
  - DISCARD: consumes bytes until TERM, then returns to IDLE without an error.
  - ECHO: present only with the macro; see Configuration.
- Execute, letters other than M: cmd_arg <= acc; cmd_pulse <= one-hot(index); pulse counter loaded with PULSE_LEN.
- Execute, M: if acc < NUM_MODES, then mode_q <= acc and mode_change pulses; no cmd_pulse is issued. Otherwise err code 2 and mode_q is unchanged.
- A new execute while a pulse is still stretching replaces the bit and the argument, and reloads the counter.
- Timeout: in ARG or DISCARD, a counter clears on every rx_done. Reaching TIMEOUT_CYC−1 raises err code 3, discards the frame and returns to IDLE.
- Reset: all outputs 0, mode_q=0, state IDLE, counters 0.

## Timing
- Terminator rx_done at cycle T → cmd_pulse high on cycles T+1 .. T+PULSE_LEN.
- mode_change and err: high on cycle T+1 only.
- All outputs are registered; there is no combinational path from rx_done or rx_data to any output.
- rx_done and a timeout expiry in the same cycle: the byte wins and the counter clears.
- reset_n asserted mid-frame or mid-pulse: outputs clear immediately; the partial frame is lost.

## Configuration
- UART_CMD_ECHO_EN defined:
  - After execute, or after err, the FSM enters ECHO and waits for tx_busy=0.
  - It then drives tx_data for one cycle with tx_start=1: 0x06 (ACK) on success, 0x15 (NAK) on error.
  - It returns to IDLE the cycle after tx_start.
  - rx_done received while in ECHO: byte dropped, err code 1.
- UART_CMD_ECHO_EN undefined: no ECHO state; tx_data=0 and tx_start=0 constant; tx_busy is ignored.

## Structure
- Package uart_cmd_pkg holds:
  - letter codes and command index localparams (CMD_U..CMD_M);
  - TERM codes;
  - ACK/NAK bytes;
  - err_code enum;
  - FSM state typedef.
- One sub-module: uart_cmd_pulse_stretch. It holds the one-hot register, the cmd_arg register and the PULSE_LEN down-counter, and is loaded on execute.

## Test plan
- "u5\r" with PULSE_LEN=4 → cmd_pulse=0x01 for 4 cycles starting T+1; cmd_arg=5.
- "M2\n" → mode_q=2 and mode_change pulses once. "M7\n" → err, err_code=2, mode_q stays 2.
- "D999\r" with ARG_W=8 → err code 2 after the third '9'; subsequent bytes discarded; no cmd_pulse.
- "R1" followed by TIMEOUT_CYC idle cycles → err code 3; the next "L\r" produces cmd_pulse=0x08 with cmd_arg=0.
- "X" in IDLE → err code 1. "C" then reset_n low mid-frame → all outputs 0; the following "\r" is ignored.
- With UART_CMD_ECHO_EN and tx_busy held high for 20 cycles after "Z\r" → tx_start=1 with tx_data=0x06 exactly one cycle after tx_busy falls.
